// File: rtl/btn_pulse.sv
// -----------------------------------------------------------------------------
// btn_pulse
//
// Turns a raw, bouncing push-button into a clean debounced level and a
// one-cycle increment strobe for a downstream modulo counter. It can optionally
// auto-repeat while the button is held.
//
// Parameters
//   DB_CYC   debounce window in clk cycles (1 .. 2^32-1)
//   RPT_EN   1 = auto-repeat enabled, 0 = single pulse per press
//   RPT_DLY  clk cycles from the first pulse to the first repeat pulse (>= 1)
//   RPT_PER  clk cycles between successive repeat pulses (>= 1)
//
// Ports
//   clk            system clock, rising-edge active
//   rst            synchronous active-high reset
//   btn_in         raw asynchronous button level, active-high
//   pulse          registered one-cycle strobe per press / repeat event
//   level          registered debounced button state
//   repeat_active  high while the FSM is auto-repeating
// -----------------------------------------------------------------------------
module btn_pulse #(
  parameter int unsigned DB_CYC  = 500000,
  parameter int unsigned RPT_EN  = 1,
  parameter int unsigned RPT_DLY = 50000000,
  parameter int unsigned RPT_PER = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic level,
  output logic repeat_active
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    REL_DB
  } state_e;

  localparam logic [31:0] DB_LAST  = 32'(DB_CYC - 1);
  localparam logic [31:0] DLY_LAST = 32'(RPT_DLY - 1);
  localparam logic [31:0] PER_LAST = 32'(RPT_PER - 1);
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;
  localparam bit          RPT_ON   = (RPT_EN != 0);

  logic   s1_q, s2_q;
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic   pulse_q, pulse_d;
  logic   level_q, level_d;
  logic   fire;
  logic   sync;

  assign sync = s2_q;

  // Two-flop synchronizer: btn_in is asynchronous, so only the second stage
  // is ever allowed to steer the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  // State, the shared window/repeat counter and the registered outputs.
  // Reset wins on its edge, so no pulse can ever leave on a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Next-state logic. One counter serves as the debounce timer in PRESS_DB
  // and REL_DB and as the repeat timer in HELD and REPEAT; every state
  // change clears it, so each state measures from its own entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    fire    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync) begin
          state_d = PRESS_DB;
        end
      end

      PRESS_DB: begin
        if (!sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          fire    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      HELD: begin
        if (!sync) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (RPT_ON && (cnt_q == DLY_LAST)) begin
          state_d = REPEAT;
          fire    = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          // Saturate so a very long hold with repeat disabled never wraps.
          cnt_d = cnt_q + 32'd1;
        end
      end

      REPEAT: begin
        if (!sync) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          fire  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      REL_DB: begin
        if (sync) begin
          // Release was only a bounce: back to HELD, level untouched.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A strobe never follows a strobe, which keeps RPT_PER=1 or RPT_DLY=1
    // from producing a pulse that is stuck high.
    pulse_d = fire & ~pulse_q;
  end

  assign pulse         = pulse_q;
  assign level         = level_q;
  assign repeat_active = (state_q == REPEAT);

endmodule

// File: tb/tb_btn_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_pulse
//
// Drives two btn_pulse instances from the same button: one with auto-repeat
// and one without. A behavioural model describes the button in terms of run
// lengths of the synchronised level and the age of the current hold. It is
// compared against both instances after every clock edge. Directed scenarios
// with hand-computed expectations come first, then randomized presses,
// bounces and resets.
// -----------------------------------------------------------------------------
module tb_btn_pulse;

  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic pulseA, levelA, repA;
  logic pulseB, levelB, repB;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  btn_pulse #(.DB_CYC(DB), .RPT_EN(1), .RPT_DLY(DLY), .RPT_PER(PER)) dutA (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .pulse(pulseA), .level(levelA), .repeat_active(repA)
  );

  btn_pulse #(.DB_CYC(DB), .RPT_EN(0), .RPT_DLY(DLY), .RPT_PER(PER)) dutB (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .pulse(pulseB), .level(levelB), .repeat_active(repB)
  );

  // Model state: a two-edge input delay, the debounced level, the length of
  // the current run of synchronised samples that disagree with the level,
  // the age of the current uninterrupted hold, and whether repeating.
  typedef struct {
    bit s1;
    bit s2;
    bit lvl;
    bit rep;
    bit pulse;
    int run;
    int age;
  } model_t;

  model_t mA, mB;

  task automatic modelStep(inout model_t m, input bit rstIn, input bit btnIn,
                           input bit rptEn);
    bit s;
    bit ev;
    if (rstIn) begin
      m.s1 = 0; m.s2 = 0; m.lvl = 0; m.rep = 0; m.pulse = 0;
      m.run = 0; m.age = 0;
      return;
    end
    s  = m.s2;
    ev = 0;
    if (!m.lvl) begin
      m.run = s ? m.run + 1 : 0;
      if (m.run == DB + 1) begin
        m.lvl = 1; m.run = 0; m.age = 0; m.rep = 0; ev = 1;
      end
    end else if (!s) begin
      m.run = m.run + 1;
      m.rep = 0;
      if (m.run == DB + 1) begin
        m.lvl = 0; m.run = 0;
      end
    end else if (m.run > 0) begin
      m.run = 0;
      m.age = 0;
    end else begin
      m.age = m.age + 1;
      if (rptEn && !m.rep && m.age == DLY) begin
        ev = 1; m.rep = 1; m.age = 0;
      end else if (rptEn && m.rep && m.age == PER) begin
        ev = 1; m.age = 0;
      end
    end
    m.s2    = m.s1;
    m.s1    = btnIn;
    m.pulse = ev && !m.pulse;
  endtask

  task automatic checkOutput(input string name, input logic act, input bit exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every edge: advance both models, then compare just after the edge.
  always begin
    @(posedge clk);
    modelStep(mA, rst, btn_in, 1'b1);
    modelStep(mB, rst, btn_in, 1'b0);
    #1;
    checkOutput("A.pulse", pulseA, mA.pulse);
    checkOutput("A.level", levelA, mA.lvl);
    checkOutput("A.repeat_active", repA, mA.rep);
    checkOutput("B.pulse", pulseB, mB.pulse);
    checkOutput("B.level", levelB, mB.lvl);
    checkOutput("B.repeat_active", repB, mB.rep);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit r, input bit b, input int n);
    rst    = r;
    btn_in = b;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt;
    int segLen;

    // Reset state.
    applyStimulus(1, 0, 2);
    checkOutput("rst.pulse", pulseA, 0);
    checkOutput("rst.level", levelA, 0);
    checkOutput("rst.repeat", repA, 0);

    // Held from edge 1: pulse after edge 7, repeats at +10, +13.
    applyStimulus(0, 1, 6);
    checkOutput("press.e6.pulse", pulseA, 0);
    checkOutput("press.e6.level", levelA, 0);
    applyStimulus(0, 1, 1);
    checkOutput("press.e7.pulse", pulseA, 1);
    checkOutput("press.e7.level", levelA, 1);
    applyStimulus(0, 1, 1);
    checkOutput("press.e8.pulse", pulseA, 0);
    checkOutput("press.e8.level", levelA, 1);
    applyStimulus(0, 1, 8);
    checkOutput("rpt.e16.pulse", pulseA, 0);
    checkOutput("rpt.e16.repeat", repA, 0);
    applyStimulus(0, 1, 1);
    checkOutput("rpt.e17.pulse", pulseA, 1);
    checkOutput("rpt.e17.repeat", repA, 1);
    checkOutput("norpt.e17.pulse", pulseB, 0);
    applyStimulus(0, 1, 2);
    checkOutput("rpt.e19.pulse", pulseA, 0);
    applyStimulus(0, 1, 1);
    checkOutput("rpt.e20.pulse", pulseA, 1);

    // Release: level falls on the 7th released edge (2 sync + 4 debounce + 1).
    applyStimulus(0, 0, 6);
    checkOutput("rel.t6.level", levelA, 1);
    applyStimulus(0, 0, 1);
    checkOutput("rel.t7.level", levelA, 0);
    applyStimulus(0, 0, 5);

    // Short press of 3 cycles is rejected.
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      btn_in = (i < 3);
      tick();
      checkOutput("short.pulse", pulseA, 0);
      checkOutput("short.level", levelA, 0);
    end

    // Low glitch of 2 cycles while held: no pulse, level stays, the repeat
    // timer restarts from the return to HELD (edge 13 -> repeat at 23).
    applyStimulus(0, 1, 8);
    applyStimulus(0, 0, 2);
    btn_in = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("glitch.pulse", pulseA, 0);
      checkOutput("glitch.level", levelA, 1);
    end
    applyStimulus(0, 1, 1);
    checkOutput("glitch.e23.pulse", pulseA, 1);
    applyStimulus(0, 0, 20);

    // Repeat disabled: exactly one pulse over a 100-cycle hold.
    cnt = 0;
    btn_in = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pulseB === 1'b1) cnt++;
    end
    vectors++;
    if (cnt != 1) begin
      miscompares++;
      $display("[TB] FAIL norpt.count: got %0d pulses expected 1", cnt);
    end
    applyStimulus(0, 0, 20);

    // Reset during PRESS_DB with cnt=2, button kept held.
    applyStimulus(0, 1, 5);
    applyStimulus(1, 1, 1);
    checkOutput("rstdb.pulse", pulseA, 0);
    checkOutput("rstdb.level", levelA, 0);
    applyStimulus(0, 1, 6);
    checkOutput("rstdb.e6.pulse", pulseA, 0);
    applyStimulus(0, 1, 1);
    checkOutput("rstdb.e7.pulse", pulseA, 1);
    applyStimulus(0, 0, 20);

    // Reset in REPEAT on the edge that would have pulsed (edge 20).
    applyStimulus(0, 1, 19);
    checkOutput("rstrpt.e19.repeat", repA, 1);
    applyStimulus(1, 1, 1);
    checkOutput("rstrpt.pulse", pulseA, 0);
    checkOutput("rstrpt.repeat", repA, 0);
    checkOutput("rstrpt.level", levelA, 0);
    applyStimulus(0, 0, 10);

    // Randomized presses, bounces, long holds and occasional resets.
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 3) == 0) segLen = $urandom_range(15, 40);
      else segLen = $urandom_range(1, 8);
      if ($urandom_range(0, 19) == 0) applyStimulus(1, 1'($urandom_range(0, 1)), 1);
      applyStimulus(0, 1'($urandom_range(0, 1)), segLen);
    end
    applyStimulus(0, 0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
